// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory/IO port between the pipeline MEM stage (CPU)
// and a debug/loader master (DBG). The CPU has fixed priority. After
// STARVE_MAX consecutive CPU grants taken while DBG was waiting, the next
// contested slot goes to DBG. Each access is sequenced over MEM_LAT cycles.
// The CPU pipeline is stalled until its own access reaches its response
// cycle.
//
// Access timeline, counted from the grant edge:
//   BUSY (MEM_LAT cycles)
//     - mem_addr and mem_wdata are held stable.
//     - Reads: mem_read is high in every BUSY cycle.
//     - Writes: mem_write is high only in the last BUSY cycle, so the
//       memory sees exactly one write edge.
//     - Read data is captured on the edge that leaves the last BUSY cycle.
//   RESP (1 cycle)
//     - mem_* are all 0.
//     - For a DBG access, dbg_ack pulses.
//     - For a CPU access, the internal done flag drops cpu_stall.
//   The next cycle is always IDLE; arbitration happens only in IDLE.
//
// Ports
//   clock, reset                  system clock (rising edge); async active-low reset
//   cpu_req/we/addr/wdata         CPU request, held until serviced
//   cpu_rdata                     CPU read data, valid in CPU RESP, then held
//   cpu_stall                     pipeline freeze (combinational)
//   dbg_req/we/addr/wdata         DBG request, held until dbg_ack
//   dbg_rdata                     DBG read data, valid with dbg_ack, then held
//   dbg_ack                       one-cycle DBG completion pulse
//   mem_addr/wdata/write/read     registered drive into DMemory_IO
//   mem_rdata                     combinational read data from DMemory_IO
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    // The latency counter is sized so that it can also hold the value 2.
    // The "write strobe next cycle" compare below needs that value, even
    // when MEM_LAT is 1.
    localparam int LAT_W = $clog2(MEM_LAT + 2);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_PENULT = LAT_W'(2);
    localparam logic [ST_W-1:0]  STARVE_LIM = ST_W'(STARVE_MAX);
    localparam bit               LAT_IS_ONE = (MEM_LAT == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              owner_dbg_r;
    logic              we_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [ST_W-1:0]   starve_cnt_r;
    logic              cpu_done_r;

    logic              grant_cpu_s;
    logic              grant_dbg_s;
    logic              sel_we_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [ST_W-1:0]   starve_nxt_s;
    logic              last_busy_s;
    logic              wr_strobe_nxt_s;

    // Arbitration: the CPU wins a contested slot unless DBG has been passed
    // over STARVE_MAX times in a row.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (cpu_req && dbg_req) begin
            if (starve_cnt_r == STARVE_LIM) begin
                grant_dbg_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b1;
            end
        end else if (cpu_req) begin
            grant_cpu_s = 1'b1;
        end else if (dbg_req) begin
            grant_dbg_s = 1'b1;
        end else begin
            grant_cpu_s = 1'b0;
            grant_dbg_s = 1'b0;
        end
    end

    // Selects the request fields of whichever master wins the slot.
    always_comb begin
        sel_we_s    = cpu_we;
        sel_addr_s  = cpu_addr;
        sel_wdata_s = cpu_wdata;
        if (grant_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Next value of the starvation counter, applied only when a grant is made.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (grant_dbg_s || (grant_cpu_s && !dbg_req)) begin
            starve_nxt_s = {ST_W{1'b0}};
        end else if (grant_cpu_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + ST_W'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Position of the current BUSY cycle within the access window.
    always_comb begin
        last_busy_s     = (lat_cnt_r == LAT_LAST);
        wr_strobe_nxt_s = we_r && (lat_cnt_r == LAT_PENULT);
    end

    // Access sequencer: owns the FSM state and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            owner_dbg_r  <= 1'b0;
            we_r         <= 1'b0;
            lat_cnt_r    <= {LAT_W{1'b0}};
            starve_cnt_r <= {ST_W{1'b0}};
            cpu_done_r   <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            cpu_rdata    <= {DW{1'b0}};
            dbg_rdata    <= {DW{1'b0}};
            dbg_ack      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dbg_ack    <= 1'b0;
                    cpu_done_r <= 1'b0;
                    if (grant_cpu_s || grant_dbg_s) begin
                        owner_dbg_r  <= grant_dbg_s;
                        we_r         <= sel_we_s;
                        mem_addr     <= sel_addr_s;
                        mem_wdata    <= sel_wdata_s;
                        mem_read     <= !sel_we_s;
                        // With a one-cycle window, the first BUSY cycle is
                        // also the last one, so the write strobe starts
                        // right away.
                        mem_write    <= sel_we_s && LAT_IS_ONE;
                        lat_cnt_r    <= LAT_INIT;
                        starve_cnt_r <= starve_nxt_s;
                        state_r      <= ST_BUSY;
                    end else begin
                        mem_addr  <= {AW{1'b0}};
                        mem_wdata <= {DW{1'b0}};
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    lat_cnt_r <= lat_cnt_r - LAT_W'(1);
                    if (last_busy_s) begin
                        // Writes leave both rdata registers untouched.
                        if (!we_r) begin
                            if (owner_dbg_r) begin
                                dbg_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end else begin
                            dbg_rdata <= dbg_rdata;
                            cpu_rdata <= cpu_rdata;
                        end
                        mem_addr   <= {AW{1'b0}};
                        mem_wdata  <= {DW{1'b0}};
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        dbg_ack    <= owner_dbg_r;
                        cpu_done_r <= !owner_dbg_r;
                        state_r    <= ST_RESP;
                    end else begin
                        mem_read  <= !we_r;
                        mem_write <= wr_strobe_nxt_s;
                        state_r   <= ST_BUSY;
                    end
                end
                ST_RESP: begin
                    mem_addr   <= {AW{1'b0}};
                    mem_wdata  <= {DW{1'b0}};
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    dbg_ack    <= 1'b0;
                    cpu_done_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    mem_addr   <= {AW{1'b0}};
                    mem_wdata  <= {DW{1'b0}};
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    dbg_ack    <= 1'b0;
                    cpu_done_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // The stall rises combinationally with cpu_req. It drops in the CPU
    // response cycle, so the pipeline advances on the edge that leaves it.
    assign cpu_stall = reset & cpu_req & ~cpu_done_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Testbench for dmem_port_arbiter. It uses two instances:
//   u_dut  : MEM_LAT = 1
//   u_dut3 : MEM_LAT = 3
// Each instance is backed by a simple combinational-read memory.
//
// Traffic on u_dut is checked against a transaction-level model that applies
// the arbitration rules with a plain integer starvation count and
// cycle-number arithmetic.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int SMAX = 4;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;

    // MEM_LAT = 1 instance
    logic        cpu_req, cpu_we, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    // MEM_LAT = 3 instance
    logic        c3_req, c3_we, c3_stall;
    logic [15:0] c3_addr, c3_wdata, c3_rdata;
    logic        d3_req, d3_we, d3_ack;
    logic [15:0] d3_addr, d3_wdata, d3_rdata;
    logic [15:0] m3_addr, m3_wdata, m3_rdata;
    logic        m3_write, m3_read;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] refmem [0:255];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          sm       = 0;
    logic [15:0] exp_cpu_rd = 16'h0000;
    logic [15:0] exp_dbg_rd = 16'h0000;
    txn_t        cq[$];
    txn_t        dq[$];
    bit          olog[$];
    logic [15:0] pre;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    dmem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut3 (
        .clock(clock), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr), .dbg_wdata(d3_wdata),
        .dbg_rdata(d3_rdata), .dbg_ack(d3_ack),
        .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_write(m3_write),
        .mem_read(m3_read), .mem_rdata(m3_rdata)
    );

    assign mem_rdata = mem_a[mem_addr[7:0]];
    assign m3_rdata  = mem_b[m3_addr[7:0]];

    always @(posedge clock) begin
        if (mem_write) mem_a[mem_addr[7:0]] <= mem_wdata;
        if (m3_write)  mem_b[m3_addr[7:0]]  <= m3_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the queued transactions on u_dut and checks every cycle against
    // the transaction-level model.
    task automatic run_traffic(input int budget, input bit gaps, input int drop_pct);
        int          n       = 0;
        int          cgap    = 0;
        int          dgap    = 0;
        bit          cdrop   = 1'b0;
        bit          ddrop   = 1'b0;
        bit          own_dbg = 1'b0;
        bit          drop;
        txn_t        cur;
        logic [15:0] rd_exp  = 16'h0000;
        int          start_c = -10;
        int          resp_c  = -10;
        int          free_c;
        free_c = cyc + 1;
        while ((cq.size() > 0 || dq.size() > 0) && n < budget) begin
            @(posedge clock);
            #1;
            cyc++;
            n++;
            if (cgap > 0) begin
                cpu_req = 1'b0;
                cgap--;
            end else if (cq.size() > 0 && !cdrop) begin
                cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata;
            end else begin
                cpu_req = 1'b0;
            end
            if (dgap > 0) begin
                dbg_req = 1'b0;
                dgap--;
            end else if (dq.size() > 0 && !ddrop) begin
                dbg_req = 1'b1; dbg_we = dq[0].we; dbg_addr = dq[0].addr; dbg_wdata = dq[0].wdata;
            end else begin
                dbg_req = 1'b0;
            end
            #3;
            if (cyc == start_c) begin
                chk("acc_addr", 64'(mem_addr), 64'(cur.addr));
                chk("acc_read", 64'(mem_read), 64'(!cur.we));
                chk("acc_write", 64'(mem_write), 64'(cur.we));
                if (cur.we) chk("acc_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end else begin
                chk("mem_idle", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'(0));
            end
            if (mem_read || mem_write) olog.push_back(mem_addr[7]);
            chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !(cyc == resp_c && !own_dbg)));
            chk("dbg_ack", 64'(dbg_ack), 64'((cyc == resp_c) && own_dbg));
            if (cyc == resp_c) begin
                if (own_dbg) begin
                    if (!cur.we) exp_dbg_rd = rd_exp;
                    chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rd));
                    void'(dq.pop_front());
                    ddrop = 1'b0;
                    dgap  = gaps ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    if (!cur.we) exp_cpu_rd = rd_exp;
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rd));
                    void'(cq.pop_front());
                    cdrop = 1'b0;
                    cgap  = gaps ? int'($urandom_range(0, 2)) : 0;
                end
            end
            if (cyc >= free_c && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) own_dbg = (sm == SMAX);
                else                    own_dbg = dbg_req;
                if (own_dbg || !dbg_req) sm = 0;
                else if (sm < SMAX)      sm++;
                cur = own_dbg ? dq[0] : cq[0];
                if (cur.we) refmem[cur.addr[7:0]] = cur.wdata;
                else        rd_exp = refmem[cur.addr[7:0]];
                start_c = cyc + 1;
                resp_c  = cyc + 2;
                free_c  = cyc + 3;
                drop = (int'($urandom_range(0, 99)) < drop_pct);
                if (own_dbg) ddrop = drop;
                else         cdrop = drop;
            end
        end
        chk("traffic_done", 64'(cq.size() == 0 && dq.size() == 0), 64'(1));
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = 16'h0; c3_wdata = 16'h0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = 16'h0; d3_wdata = 16'h0;
        for (int i = 0; i < 256; i++) begin
            v = (i == 32) ? 16'h1234 : 16'($urandom);
            mem_a[i] <= v;
            mem_b[i] <= v;
            refmem[i] = v;
        end

        // Reset state, with cpu_req high to show the stall is gated by reset.
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_cpu_stall", 64'(cpu_stall), 64'(0));
        chk("rst_dbg_ack", 64'(dbg_ack), 64'(0));
        chk("rst_mem", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'(0));
        chk("rst_rdata", 64'({cpu_rdata, dbg_rdata}), 64'(0));
        chk("rst_mem3", 64'({m3_read, m3_write, m3_addr, c3_stall, d3_ack}), 64'(0));
        cpu_req = 1'b0;
        reset = 1'b1;

        // T1: CPU read of 0x20.
        cq.push_back('{1'b0, 16'h0020, 16'h0000});
        run_traffic(50, 1'b0, 0);
        chk("T1_rdata", 64'(cpu_rdata), 64'(16'h1234));

        // T2: DBG write, then a CPU read-back.
        dq.push_back('{1'b1, 16'h0030, 16'h00AA});
        run_traffic(50, 1'b0, 0);
        cq.push_back('{1'b0, 16'h0030, 16'h0000});
        run_traffic(50, 1'b0, 0);
        chk("T2_mem", 64'(mem_a[8'h30]), 64'(16'h00AA));
        chk("T2_readback", 64'(cpu_rdata), 64'(16'h00AA));

        // T3: both masters held continuously; check the starvation grant order.
        olog.delete();
        for (int i = 0; i < 10; i++)
            cq.push_back('{i[0], 16'h0040 + 16'(i), 16'(16'h1100 + i)});
        for (int i = 0; i < 2; i++)
            dq.push_back('{1'b0, 16'h0080 + 16'(i), 16'h0000});
        run_traffic(200, 1'b0, 0);
        chk("T3_grant_count", 64'(olog.size()), 64'(12));
        for (int i = 0; i < 12 && i < olog.size(); i++)
            chk("T3_grant_order", 64'(olog[i]), 64'(i == 4 || i == 9));

        // T6: requests dropped right after the grant still complete.
        dq.push_back('{1'b1, 16'h00A0, 16'h0C0C});
        run_traffic(50, 1'b0, 100);
        cq.push_back('{1'b1, 16'h00A1, 16'h0D0D});
        run_traffic(50, 1'b0, 100);
        chk("T6_dbg_write", 64'(mem_a[8'hA0]), 64'(16'h0C0C));
        chk("T6_cpu_write", 64'(mem_a[8'hA1]), 64'(16'h0D0D));

        // Random mixed traffic, with gaps and occasional dropped requests.
        for (int i = 0; i < 40; i++) begin
            cq.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom)});
            dq.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom)});
        end
        run_traffic(2000, 1'b1, 20);

        // T5: reset asserted in the BUSY cycle of a CPU write.
        @(posedge clock);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hBEEF;
        pre = mem_a[8'h50];
        @(posedge clock);
        #1;
        chk("T5_busy_write", 64'(mem_write), 64'(1));
        chk("T5_busy_stall", 64'(cpu_stall), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("T5_rst_mem", 64'({mem_read, mem_write, mem_addr, mem_wdata}), 64'(0));
        chk("T5_rst_flags", 64'({cpu_stall, dbg_ack}), 64'(0));
        chk("T5_rst_rdata", 64'({cpu_rdata, dbg_rdata}), 64'(0));
        @(posedge clock);
        #1;
        chk("T5_mem_kept", 64'(mem_a[8'h50]), 64'(pre));
        cpu_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        sm = 0;
        exp_cpu_rd = 16'h0000;
        exp_dbg_rd = 16'h0000;
        cq.push_back('{1'b0, 16'h0050, 16'h0000});
        run_traffic(50, 1'b0, 0);
        chk("T5_fresh_read", 64'(cpu_rdata), 64'(pre));

        // T4: MEM_LAT=3 CPU write, then a read-back.
        @(posedge clock);
        #1;
        c3_req = 1'b1; c3_we = 1'b1; c3_addr = 16'h0060; c3_wdata = 16'h5A5A;
        #3;
        chk("T4_arb_stall", 64'(c3_stall), 64'(1));
        chk("T4_arb_mem", 64'({m3_read, m3_write}), 64'(0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #4;
            chk("T4_busy_stall", 64'(c3_stall), 64'(1));
            chk("T4_busy_read", 64'(m3_read), 64'(0));
            chk("T4_busy_write", 64'(m3_write), 64'(k == 2));
            chk("T4_busy_addr", 64'({m3_addr, m3_wdata}), 64'({16'h0060, 16'h5A5A}));
        end
        @(posedge clock);
        #4;
        chk("T4_resp_stall", 64'(c3_stall), 64'(0));
        chk("T4_resp_mem", 64'({m3_read, m3_write, m3_addr}), 64'(0));
        chk("T4_mem", 64'(mem_b[8'h60]), 64'(16'h5A5A));
        chk("T4_wr_keeps_rdata", 64'(c3_rdata), 64'(0));
        c3_req = 1'b0;
        @(posedge clock);
        #1;
        c3_req = 1'b1; c3_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #4;
            chk("T4_rd_busy", 64'({c3_stall, m3_read, m3_write}), 64'(3'b110));
        end
        @(posedge clock);
        #4;
        chk("T4_rd_resp_stall", 64'(c3_stall), 64'(0));
        chk("T4_rd_rdata", 64'(c3_rdata), 64'(16'h5A5A));
        c3_req = 1'b0;
        @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
